// File: rtl/interval_buffer.sv
// interval_buffer: captures interval measurements into a first-word-fall-through
// FIFO drained over a valid/ready stream, and keeps running statistics.
// Optional feature macro: INTERVAL_BUFFER_STATS_EN (count/min/max/sum logic).
module interval_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [DATA_W-1:0]          data_i,
  input  logic                       valid_i,
  input  logic                       clear_i,
  output logic [DATA_W-1:0]          m_data_o,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       overflow_o,
  output logic [CNT_W-1:0]           count_o,
  output logic [DATA_W-1:0]          min_o,
  output logic [DATA_W-1:0]          max_o,
  output logic [DATA_W+CNT_W-1:0]    sum_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned SUM_W = DATA_W + CNT_W;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } state_e;

  state_e              state_q;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [PTR_W-1:0]    rd_q, rd_d;
  logic [PTR_W-1:0]    wr_q, wr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   head_q, head_d;
  logic                m_valid_q;
  logic                full_q;
  logic                overflow_q;
  logic                push, pop, drop;

  // Handshake decode, next pointers/level and the next head value
  always_comb begin
    pop     = m_valid_q & m_ready_i;
    push    = valid_i & ((state_q != ST_FULL) | pop);
    drop    = valid_i & (state_q == ST_FULL) & ~pop;
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    rd_d    = rd_q + PTR_W'(pop);
    wr_d    = wr_q + PTR_W'(push);
    head_d  = '0;
    if (level_d != '0) begin
      // The written slot becomes head only when it is the sole remaining entry
      if (push && (wr_q == rd_d)) head_d = data_i;
      else                        head_d = mem_q[rd_d];
    end
  end

  // Storage array; contents need no reset since the head register masks them
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= data_i;
  end

  // FIFO control FSM with registered stream/status outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_EMPTY;
      level_q   <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      head_q    <= '0;
      m_valid_q <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      head_q  <= head_d;
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_q   <= ST_ACTIVE;
            m_valid_q <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (push && !pop && (level_q == LVL_W'(DEPTH - 1))) begin
            state_q <= ST_FULL;
            full_q  <= 1'b1;
          end else if (pop && !push && (level_q == LVL_W'(1))) begin
            state_q   <= ST_EMPTY;
            m_valid_q <= 1'b0;
          end
        end
        ST_FULL: begin
          if (pop && !push) begin
            state_q <= ST_ACTIVE;
            full_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_EMPTY;
          m_valid_q <= 1'b0;
          full_q    <= 1'b0;
        end
      endcase
    end
  end

  // Sticky drop flag; a clear in the same cycle as a drop wins
  always_ff @(posedge clk_i) begin
    if (rst_i)        overflow_q <= 1'b0;
    else if (clear_i) overflow_q <= 1'b0;
    else if (drop)    overflow_q <= 1'b1;
  end

  assign m_data_o   = head_q;
  assign m_valid_o  = m_valid_q;
  assign level_o    = level_q;
  assign full_o     = full_q;
  assign overflow_o = overflow_q;

`ifdef INTERVAL_BUFFER_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] min_q;
  logic [DATA_W-1:0] max_q;
  logic [SUM_W-1:0]  sum_q;

  // Running statistics over every reported sample, frozen once count saturates
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count_q <= '0;
      sum_q   <= '0;
      min_q   <= '1;
      max_q   <= '0;
    end else if (valid_i && (count_q != CNT_MAX)) begin
      count_q <= count_q + CNT_W'(1);
      sum_q   <= sum_q + SUM_W'(data_i);
      if (data_i < min_q) min_q <= data_i;
      if (data_i > max_q) max_q <= data_i;
    end
  end

  assign count_o = count_q;
  assign min_o   = min_q;
  assign max_o   = max_q;
  assign sum_o   = sum_q;
`else
  assign count_o = '0;
  assign min_o   = '1;
  assign max_o   = '0;
  assign sum_o   = '0;
`endif

endmodule

// File: tb/tb_interval_buffer.sv
// Directed, table-driven bench for interval_buffer (DATA_W=8, DEPTH=8, CNT_W=16).
module tb_interval_buffer;

`ifdef INTERVAL_BUFFER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  data_i = '0;
  logic        valid_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        m_ready_i = 1'b0;
  logic [7:0]  m_data_o;
  logic        m_valid_o;
  logic [3:0]  level_o;
  logic        full_o;
  logic        overflow_o;
  logic [15:0] count_o;
  logic [7:0]  min_o;
  logic [7:0]  max_o;
  logic [23:0] sum_o;

  int n_cmp = 0;
  int n_err = 0;

  interval_buffer #(.DATA_W(8), .DEPTH(8), .CNT_W(16)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .clear_i    (clear_i),
    .m_data_o   (m_data_o),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .level_o    (level_o),
    .full_o     (full_o),
    .overflow_o (overflow_o),
    .count_o    (count_o),
    .min_o      (min_o),
    .max_o      (max_o),
    .sum_o      (sum_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int r, v, d, rdy, clr;
    int ev, ed, el, ef, eo;
    int ec, emin, emax, esum;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int r, input int v, input int d, input int rdy,
                              input int clr, input int ev, input int ed, input int el,
                              input int ef, input int eo, input int ec, input int emin,
                              input int emax, input int esum);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.rdy = rdy; x.clr = clr;
    x.ev = ev; x.ed = ed; x.el = el; x.ef = ef; x.eo = eo;
    x.ec = ec; x.emin = emin; x.emax = emax; x.esum = esum;
    return x;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, step past the edge, compare every output
  task automatic apply(input string tag, input vec_t e);
    rst_i     = e.r[0];
    valid_i   = e.v[0];
    data_i    = 8'(e.d);
    m_ready_i = e.rdy[0];
    clear_i   = e.clr[0];
    @(posedge clk_i);
    #1;
    chk({tag, ".valid"},    int'(m_valid_o),  e.ev);
    chk({tag, ".data"},     int'(m_data_o),   e.ed);
    chk({tag, ".level"},    int'(level_o),    e.el);
    chk({tag, ".full"},     int'(full_o),     e.ef);
    chk({tag, ".overflow"}, int'(overflow_o), e.eo);
    chk({tag, ".count"},    int'(count_o),    STATS ? e.ec   : 0);
    chk({tag, ".min"},      int'(min_o),      STATS ? e.emin : 255);
    chk({tag, ".max"},      int'(max_o),      STATS ? e.emax : 0);
    chk({tag, ".sum"},      int'(sum_o),      STATS ? e.esum : 0);
  endtask

  initial begin
    int s;
    // Basic push/pop, clear, fill to overflow and drain
    tbl.push_back(mk(0, 1,   5, 0, 0, 1, 5, 1, 0, 0, 1, 5,   5,   5));
    tbl.push_back(mk(0, 1, 200, 0, 0, 1, 5, 2, 0, 0, 2, 5, 200, 205));
    tbl.push_back(mk(0, 1,  17, 0, 0, 1, 5, 3, 0, 0, 3, 5, 200, 222));
    tbl.push_back(mk(0, 0,   0, 1, 0, 1, 200, 2, 0, 0, 3, 5, 200, 222));
    tbl.push_back(mk(0, 0,   0, 1, 0, 1, 17, 1, 0, 0, 3, 5, 200, 222));
    tbl.push_back(mk(0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 3, 5, 200, 222));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 3, 5, 200, 222));
    tbl.push_back(mk(0, 0,   0, 0, 1, 0, 0, 0, 0, 0, 0, 255, 0, 0));
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(0, 1, i, 0, 0, 1, 1, i, (i == 8) ? 1 : 0, 0, i, 1, i, i * (i + 1) / 2));
    tbl.push_back(mk(0, 1, 9, 0, 0, 1, 1, 8, 1, 1, 9, 1, 9, 45));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(0, 0, 0, 1, 0, (k < 8) ? 1 : 0, (k < 8) ? k + 1 : 0, 8 - k, 0, 1,
                       9, 1, 9, 45));

    // Reset state
    apply("reset0", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 255, 0, 0));
    apply("reset1", mk(1, 1, 33, 1, 0, 0, 0, 0, 0, 0, 0, 255, 0, 0));

    foreach (tbl[i]) apply($sformatf("tbl%0d", i), tbl[i]);

    // Clear alone drops the sticky overflow
    apply("clr", mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 255, 0, 0));

    // Refill, then push and pop together while full
    s = 0;
    for (int i = 1; i <= 8; i++) begin
      s += i;
      apply($sformatf("refill%0d", i),
            mk(0, 1, i, 0, 0, 1, 1, i, (i == 8) ? 1 : 0, 0, i, 1, i, s));
    end
    apply("full_pp", mk(0, 1, 42, 1, 0, 1, 2, 8, 1, 0, 9, 1, 42, 78));
    for (int k = 1; k <= 8; k++)
      apply($sformatf("drain%0d", k),
            mk(0, 0, 0, 1, 0, (k < 8) ? 1 : 0, (k < 7) ? k + 2 : ((k == 7) ? 42 : 0),
               8 - k, 0, 0, 9, 1, 42, 78));

    // Streaming at one per cycle wraps both pointers without growth
    s = 78;
    for (int i = 0; i < 20; i++) begin
      s += 100 + i;
      apply($sformatf("stream%0d", i),
            mk(0, 1, 100 + i, 1, 0, 1, 100 + i, 1, 0, 0, 10 + i, 1, 100 + i, s));
    end
    apply("stream_end", mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 29, 1, 119, 2268));

    // Clear wins over a simultaneous sample for stats; FIFO still takes it
    apply("clr_push", mk(0, 1, 99, 0, 1, 1, 99, 1, 0, 0, 0, 255, 0, 0));
    s = 0;
    for (int j = 1; j <= 7; j++) begin
      s += 50 + j;
      apply($sformatf("fill2_%0d", j),
            mk(0, 1, 50 + j, 0, 0, 1, 99, 1 + j, (j == 7) ? 1 : 0, 0, j, 51, 50 + j, s));
    end
    // Drop coinciding with clear is not recorded as overflow
    apply("clr_drop", mk(0, 1, 77, 0, 1, 1, 99, 8, 1, 0, 0, 255, 0, 0));
    for (int k = 1; k <= 4; k++)
      apply($sformatf("pop2_%0d", k),
            mk(0, 0, 0, 1, 0, 1, 50 + k, 8 - k, 0, 0, 0, 255, 0, 0));

    // Reset mid-operation dominates valid/clear and flushes the FIFO
    apply("rst_mid", mk(1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 255, 0, 0));
    apply("post_rst", mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 255, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
